// File: rtl/input_injector.sv
// input_injector
//
// Input layer of the integer echo state network. One signed input sample is
// multiplied by a fixed signed weight per neuron, one neuron per clock, and the
// per-neuron results are packed into a vector that is published atomically
// together with a one-cycle ready strobe.
//
// Optional feature macro: INJECTOR_SATURATE_EN
//   defined     -> each product is clamped to the signed data_width range
//   not defined -> each product keeps only its low data_width bits (wrap)
//
// Ports:
//   iClk    in   clock, rising edge
//   iRst_n  in   asynchronous active-low reset
//   iEn     in   start request, only looked at while idle
//   iValue  in   signed input sample [data_width]
//   oData   out  packed injected vector, neuron n at [n*data_width +: data_width]
//   oBusy   out  high while a sample is being processed
//   oRdy    out  one-cycle strobe, oData has just been updated

module input_injector #(
    parameter int reservoir_size = 4,
    parameter int data_width     = 3,
    parameter int weight_size    = 2,
    parameter logic [reservoir_size*weight_size-1:0] INPUT_WEIGHTS = 8'b01_11_10_01
) (
    input  logic                                 iClk,
    input  logic                                 iRst_n,
    input  logic                                 iEn,
    input  logic [data_width-1:0]                iValue,
    output logic [reservoir_size*data_width-1:0] oData,
    output logic                                 oBusy,
    output logic                                 oRdy
);

    localparam int IDXW = (reservoir_size > 1) ? $clog2(reservoir_size) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(reservoir_size - 1);

`ifdef INJECTOR_SATURATE_EN
    // Full product width so the clamp sees the true value.
    localparam int PW = data_width + weight_size;
    localparam logic signed [PW-1:0] MAX_VAL = PW'(2 ** (data_width - 1) - 1);
    localparam logic signed [PW-1:0] MIN_VAL = PW'(-(2 ** (data_width - 1)));
`else
    // The low bits of a two's-complement product depend only on the low bits
    // of its operands, so wrapping needs a data_width multiplier only.
    localparam int PW = data_width;
`endif

    typedef enum logic {
        IDLE,
        CALC
    } stateT;

    stateT                               state;
    logic [IDXW-1:0]                     idx;
    logic [data_width-1:0]               sample;
    logic [reservoir_size*data_width-1:0] shadow;
    logic [reservoir_size*data_width-1:0] shadowNext;
    logic [weight_size-1:0]              weight;
    logic signed [PW-1:0]                sampleExt;
    logic signed [PW-1:0]                weightExt;
    logic signed [PW-1:0]                product;
    logic [data_width-1:0]               clipped;

    // Datapath for the neuron selected by idx: pick its weight, multiply,
    // reduce to data_width, and merge into a copy of the shadow vector so the
    // completion edge can publish the last slice together with the rest.
    always_comb begin
        weight    = INPUT_WEIGHTS[idx*weight_size +: weight_size];
        sampleExt = PW'($signed(sample));
        weightExt = PW'($signed(weight));
        product   = sampleExt * weightExt;
`ifdef INJECTOR_SATURATE_EN
        if (product > MAX_VAL) begin
            clipped = MAX_VAL[data_width-1:0];
        end else if (product < MIN_VAL) begin
            clipped = MIN_VAL[data_width-1:0];
        end else begin
            clipped = product[data_width-1:0];
        end
`else
        clipped = product[data_width-1:0];
`endif
        shadowNext = shadow;
        shadowNext[idx*data_width +: data_width] = clipped;
    end

    // Control FSM with registered outputs. oData is only written on the
    // completion edge, so consumers never observe a partially built vector.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state  <= IDLE;
            idx    <= '0;
            sample <= '0;
            shadow <= '0;
            oData  <= '0;
            oBusy  <= 1'b0;
            oRdy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oRdy <= 1'b0;
                    if (iEn) begin
                        sample <= iValue;
                        idx    <= '0;
                        oBusy  <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    shadow <= shadowNext;
                    if (idx == LAST_IDX) begin
                        oData <= shadowNext;
                        oRdy  <= 1'b1;
                        oBusy <= 1'b0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_injector.sv
// tb_input_injector
//
// Directed bench for input_injector with default parameters and weights
// n0=1, n1=-2, n2=-1, n3=1. Inputs are driven and outputs sampled on the
// falling clock edge; the rising edge is the active edge of the design.
// Expected vectors follow INJECTOR_SATURATE_EN so the bench fits either build.
//
// Ports of the design under test: iClk, iRst_n, iEn, iValue, oData, oBusy, oRdy.

module tb_input_injector;

    logic        iClk;
    logic        iRst_n;
    logic        iEn;
    logic [2:0]  iValue;
    logic [11:0] oData;
    logic        oBusy;
    logic        oRdy;

    int vectors;
    int miscompares;
    int rdyCount;
    int cycleNum;
    logic [11:0] prevData;
    logic        prevRst;

`ifdef INJECTOR_SATURATE_EN
    localparam logic [11:0] EXP_POS3 = 12'b011_101_100_011;
    localparam logic [11:0] EXP_NEG4 = 12'b100_011_011_100;
`else
    localparam logic [11:0] EXP_POS3 = 12'b011_101_010_011;
    localparam logic [11:0] EXP_NEG4 = 12'b100_100_000_100;
`endif
    localparam logic [11:0] EXP_POS1 = 12'b001_111_110_001;
    localparam logic [11:0] EXP_NEG1 = 12'b111_001_010_111;

    input_injector dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iEn    (iEn),
        .iValue (iValue),
        .oData  (oData),
        .oBusy  (oBusy),
        .oRdy   (oRdy)
    );

    // Free-running 10 ns clock.
    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // One comparison: count it, and on a mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge, then check that oData only moved on a
    // cycle where oRdy is high, and tally ready strobes.
    task automatic tick();
        @(negedge iClk);
        cycleNum++;
        if (iRst_n && prevRst) begin
            checkOutput("stable", {31'd0, (oData !== prevData) && !oRdy}, 32'd0);
        end
        if (iRst_n && oRdy) rdyCount++;
        prevData = oData;
        prevRst  = iRst_n;
    endtask

    // Drive the request inputs for the next rising edge.
    task automatic applyStimulus(input logic en, input logic [2:0] value);
        iEn    = en;
        iValue = value;
    endtask

    // Wait a bounded number of cycles for oRdy; returns cycles waited.
    task automatic waitRdy(output int waited);
        waited = 0;
        while (!oRdy && waited < 12) begin
            tick();
            waited++;
        end
    endtask

    // Full transaction: request, acceptance, latency, result, strobe width.
    task automatic runSample(input string tag, input logic [2:0] value,
                             input logic [11:0] expected);
        int waited;
        applyStimulus(1'b1, value);
        tick();
        applyStimulus(1'b0, 3'b000);
        checkOutput({tag, ".busy"}, {31'd0, oBusy}, 32'd1);
        waitRdy(waited);
        checkOutput({tag, ".latency"}, waited, 32'd4);
        checkOutput({tag, ".data"}, {20'd0, oData}, {20'd0, expected});
        checkOutput({tag, ".busyLow"}, {31'd0, oBusy}, 32'd0);
        tick();
        checkOutput({tag, ".rdyPulse"}, {31'd0, oRdy}, 32'd0);
    endtask

    initial begin
        int waited;
        int rdyBefore;
        int rdyCycles[$];
        vectors     = 0;
        miscompares = 0;
        rdyCount    = 0;
        cycleNum    = 0;
        prevData    = '0;
        prevRst     = 1'b0;
        iRst_n      = 1'b0;
        applyStimulus(1'b0, 3'b000);

        // Reset state.
        tick();
        tick();
        checkOutput("reset.data", {20'd0, oData}, 32'd0);
        checkOutput("reset.busy", {31'd0, oBusy}, 32'd0);
        checkOutput("reset.rdy", {31'd0, oRdy}, 32'd0);
        iRst_n = 1'b1;
        tick();
        tick();
        checkOutput("idle.busy", {31'd0, oBusy}, 32'd0);

        // Main function across several sample values and both extremes.
        runSample("pos3", 3'b011, EXP_POS3);
        runSample("neg4", 3'b100, EXP_NEG4);
        runSample("zero", 3'b000, 12'd0);
        runSample("neg1", 3'b111, EXP_NEG1);
        runSample("pos1", 3'b001, EXP_POS1);

        // Busy rejection: a second request one cycle after acceptance is dropped.
        tick();
        rdyBefore = rdyCount;
        applyStimulus(1'b1, 3'b011);
        tick();
        applyStimulus(1'b1, 3'b001);
        tick();
        applyStimulus(1'b0, 3'b000);
        waitRdy(waited);
        checkOutput("reject.latency", waited, 32'd3);
        checkOutput("reject.data", {20'd0, oData}, {20'd0, EXP_POS3});
        for (int i = 0; i < 10; i++) tick();
        checkOutput("reject.rdyCount", rdyCount - rdyBefore, 32'd1);
        checkOutput("reject.dataHeld", {20'd0, oData}, {20'd0, EXP_POS3});

        // Held request: one result every five cycles.
        applyStimulus(1'b1, 3'b001);
        for (int i = 0; i < 17; i++) begin
            tick();
            if (oRdy) rdyCycles.push_back(cycleNum);
        end
        applyStimulus(1'b0, 3'b000);
        checkOutput("held.count", rdyCycles.size(), 32'd3);
        if (rdyCycles.size() >= 3) begin
            checkOutput("held.gap1", rdyCycles[1] - rdyCycles[0], 32'd5);
            checkOutput("held.gap2", rdyCycles[2] - rdyCycles[1], 32'd5);
        end
        checkOutput("held.data", {20'd0, oData}, {20'd0, EXP_POS1});
        for (int i = 0; i < 6; i++) tick();

        // Mid-operation reset, asserted between edges two cycles after acceptance.
        rdyBefore = rdyCount;
        applyStimulus(1'b1, 3'b011);
        tick();
        applyStimulus(1'b0, 3'b000);
        tick();
        #2;
        iRst_n = 1'b0;
        #1;
        checkOutput("midReset.data", {20'd0, oData}, 32'd0);
        checkOutput("midReset.busy", {31'd0, oBusy}, 32'd0);
        checkOutput("midReset.rdy", {31'd0, oRdy}, 32'd0);
        tick();
        iRst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checkOutput("midReset.noRdy", rdyCount - rdyBefore, 32'd0);
        checkOutput("midReset.dataZero", {20'd0, oData}, 32'd0);
        runSample("afterReset", 3'b100, EXP_NEG4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_injector.md
# input_injector

Input layer of the integer echo state network: accepts one signed scalar input sample and expands it into the per-neuron input vector that drives the reservoir. Each neuron's contribution is the sample times a fixed signed input weight, clipped to `data_width`. It is the counterpart of the readout interpreter, which collapses the reservoir vector to a scalar.

- Neurons are processed sequentially, one multiplier per cycle.
- The packed vector is published atomically with a one-cycle ready strobe.

## Interface
- `reservoir_size`, 4, number of neurons / output slices.
- `data_width`, 3, signed width of the input sample and of each output slice.
- `weight_size`, 2, signed width of each input weight.
- `INPUT_WEIGHTS`, `8'b01_11_10_01`, packed `reservoir_size*weight_size` weights; neuron 0 sits in the LSBs.

Ports:
- `iClk`  in  1  clock; all logic on the rising edge.
- `iRst_n`  in  1  reset, asynchronous, active-low.
- `iEn`  in  1  start request; sampled only in IDLE.
- `iValue`  in  `data_width`  signed input sample, captured on acceptance.
- `oData`  out  `reservoir_size*data_width`  packed injected vector; neuron n occupies bits `[n*data_width +: data_width]`.
- `oBusy`  out  1  high while a sample is being processed.
- `oRdy`  out  1  one-cycle strobe: `oData` has just been updated.

## Operation
- **States:** IDLE, CALC.
- **IDLE:** on a rising edge with `iEn`=1:
  - latch `iValue` into the sample register;
  - clear neuron index `idx` to 0;
  - go to CALC.
  - `iEn`=0 keeps the block in IDLE.
- **CALC:** each edge computes `product = sample * w[idx]`.
  - Signed × signed, full width `data_width+weight_size`.
  - The result is reduced to `data_width` (see Configuration) and written into slice `idx` of an internal shadow vector.
  - `idx` increments.
- **Completion:** at the edge where `idx = reservoir_size-1`:
  - the shadow vector, including this last slice, is copied to `oData`;
  - `oRdy` is set;
  - the state returns to IDLE.
- **`oData` stability:** `oData` changes only on the completion edge and never shows partial vectors.
- **`iEn` while in CALC:** ignored, not queued. `iValue` changes during CALC have no effect.
- **Back-to-back:** a new `iEn` is accepted in the cycle `oRdy` is high, because the state is IDLE.
- **Reset (asynchronous, any time, including mid-CALC):**
  - state goes to IDLE, `idx`=0;
  - sample, shadow and `oData` are all zeros;
  - `oBusy`=0, `oRdy`=0;
  - an aborted sample produces no `oRdy`.
- **`reservoir_size`=1:** the single CALC edge is also the completion edge.

## Timing
- Acceptance edge is A.
- `oBusy`=1 from edge A through edge A+`reservoir_size`, then 0 unless a new sample is accepted on that edge.
- `oData` and `oRdy` update at edge A+`reservoir_size`; `oRdy` is high for exactly one cycle.
- Throughput: one sample per `reservoir_size`+1 cycles with `iEn` held high.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `INJECTOR_SATURATE_EN` defined: each product is clamped to [-2^(`data_width`-1), 2^(`data_width`-1)-1]. For `data_width`=3 the range is [-4, 3].
- Not defined: the product is truncated to its low `data_width` bits (two's-complement wrap). There is no clamp logic.

## Test plan
All cases use the default parameters and the default `INPUT_WEIGHTS`, i.e. weights n0=1, n1=-2, n2=-1, n3=1.

- **Basic, saturation on:** `iValue`=3'b011, `iEn` pulse → `oRdy` high exactly 4 edges after acceptance; `oData`=12'b011_101_100_011.
- **Basic, saturation off:** same stimulus without `INJECTOR_SATURATE_EN` → `oData`=12'b011_101_010_011.
- **Negative extreme, saturation on:** `iValue`=3'b100 → `oData`=12'b100_011_011_100. Also `iValue`=0 → `oData`=0.
- **Busy rejection:** second `iEn` with `iValue`=3'b001 one cycle after acceptance → ignored; only one `oRdy`, carrying the first sample's result. Then hold `iEn`=1 → `oRdy` every 5 cycles.
- **Mid-operation reset:** assert `iRst_n`=0 two cycles after acceptance, asynchronously between edges → `oData`, `oBusy`, `oRdy` go to 0 immediately; no `oRdy` after release; the next sample completes normally.
- **Stability:** check every cycle that `oData` changes only on cycles where `oRdy` rises.
